// File: rtl/seq_mul_approx_if.sv
// Handshake/data bundle for seq_mul_approx.
//   in_valid/in_ready   : operand pair + mode offered / accepted
//   in_a, in_b          : unsigned operands, W bits
//   in_approx           : 1 = truncated partial products, 0 = exact
//   out_valid/out_ready : result offered / consumed
//   out_p               : product, OUT_W bits
// master = operand producer / result consumer, slave = the multiplier.
interface seq_mul_approx_if #(
  parameter int unsigned W     = 4,
  parameter int unsigned OUT_W = 2 * W
) ();
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_approx;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_p;

  modport master (
    output in_valid, in_a, in_b, in_approx, out_ready,
    input  in_ready, out_valid, out_p
  );

  modport slave (
    input  in_valid, in_a, in_b, in_approx, out_ready,
    output in_ready, out_valid, out_p
  );
endinterface

// File: rtl/seq_mul_approx.sv
// Sequential shift-add unsigned multiplier with optional truncated (approximate) mode.
// One multiplier bit is consumed per clock, LSB first, so a result is ready exactly W
// edges after the operands are accepted.
//   clk   : clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : seq_mul_approx_if.slave (operand/result handshakes, see interface file)
// In approximate mode, each shifted partial product has its TRUNC_K low bits cleared
// before accumulation. The accumulator is 2*W bits; out_p is its low OUT_W bits.
module seq_mul_approx #(
  parameter int unsigned W       = 4,
  parameter int unsigned OUT_W   = 2 * W,
  parameter int unsigned TRUNC_K = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  seq_mul_approx_if.slave   bus
);

  localparam int unsigned AccW = 2 * W;
  localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

  localparam logic [AccW-1:0] AccOne    = AccW'(1);
  // Keeps bit positions >= TRUNC_K; all ones when TRUNC_K = 0.
  localparam logic [AccW-1:0] TruncMask = ~((AccOne << TRUNC_K) - AccOne);
  localparam logic [CntW-1:0] CntLast   = CntW'(W - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            approx_q, approx_d;
  logic [AccW-1:0] acc_q, acc_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [AccW-1:0] pp_shift;
  logic [AccW-1:0] pp_masked;

  assign pp_shift  = {{W{1'b0}}, a_q} << cnt_q;
  assign pp_masked = approx_q ? (pp_shift & TruncMask) : pp_shift;

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid) begin
          a_d      = bus.in_a;
          b_d      = bus.in_b;
          approx_d = bus.in_approx;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = StBusy;
        end
      end
      StBusy: begin
        if (b_q[cnt_q]) begin
          acc_d = acc_q + pp_masked;
        end
        if (cnt_q == CntLast) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= 1'b0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StDone);
  assign bus.out_p     = acc_q[OUT_W-1:0];

endmodule

// File: doc/seq_mul_approx.md
SEQ_MUL_APPROX -- requirements
Module: seq_mul_approx

Interface
REQ-001 The block SHALL have parameter W, default 4, giving the unsigned operand width; legal range 2..16.
REQ-002 The block SHALL have parameter OUT_W, default 2*W, giving the product output width; legal range 1..2*W.
REQ-003 The block SHALL have parameter TRUNC_K, default 2, giving the number of least-significant partial-product columns dropped in approximate mode; legal range 0..2*W-1.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous and active-low.
REQ-006 in_valid  input  1  operand pair and mode are valid this cycle.
REQ-007 in_ready  output  1  block can accept an operand pair.
REQ-008 in_a  input  W  multiplicand, unsigned.
REQ-009 in_b  input  W  multiplier, unsigned.
REQ-010 in_approx  input  1  1 = approximate mode, 0 = exact mode; sampled with the operands.
REQ-011 out_valid  output  1  out_p holds a completed result.
REQ-012 out_ready  input  1  consumer accepts the result this cycle.
REQ-013 out_p  output  OUT_W  product, the low OUT_W bits of the internal 2*W-bit accumulator.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-015 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE with in_valid=1, the block SHALL capture in_a, in_b and in_approx, clear the accumulator and bit counter, and enter BUSY.
REQ-017 Each BUSY edge SHALL process multiplier bit i (i = 0..W-1, LSB first): if b_i=1, add (a << i), masked per REQ-018, into the 2*W-bit accumulator.
REQ-018 In approximate mode, bits at positions below TRUNC_K in each shifted partial product SHALL be forced to 0 before accumulation; exact mode SHALL apply no mask, and TRUNC_K=0 SHALL make both modes identical.
REQ-019 Accumulation SHALL be 2*W bits wide with no overflow possible; truncation to OUT_W SHALL occur only at out_p.
REQ-020 After the W-th BUSY edge the FSM SHALL enter DONE, so out_valid rises exactly W rising edges after the accepting edge, independent of operand values (zeros included).
REQ-021 In DONE, out_p SHALL remain stable while out_ready=0; on out_ready=1 the FSM SHALL return to IDLE on that edge.
REQ-022 in_valid SHALL be ignored in BUSY and DONE; an in_valid held through DONE SHALL be accepted in the cycle after return to IDLE.
REQ-023 Input operands SHALL not be observed after the accepting edge; changes to in_a, in_b or in_approx during BUSY SHALL not affect the result.
REQ-024 out_p SHALL hold the accumulator value in every state; its value outside DONE is don't-care for the consumer but SHALL be deterministic.

Reset
REQ-025 With rst_n=0 at a rising edge the block SHALL enter IDLE, clear the accumulator, operand registers, mode flag and counter, and drive in_ready=1, out_valid=0, out_p=0 after that edge.
REQ-026 Reset asserted in BUSY or DONE SHALL abort the operation with no result delivered; the first edge with rst_n=1 SHALL behave as IDLE.

Verification (W=4, OUT_W=8, TRUNC_K=2)
REQ-027 Exact: a=15, b=15, approx=0, out_ready=1 -> out_valid exactly 4 edges after accept, out_p=225, IDLE one edge later.
REQ-028 Approx: a=15, b=15, approx=1 -> out_p=220 (12+28+60+120); a=3, b=1, approx=1 -> out_p=0.
REQ-029 Backpressure: a=7, b=9 exact, out_ready=0 for 3 cycles -> out_p=63 stable, out_valid=1 throughout, in_ready=0 until the edge after out_ready=1.
REQ-030 Mid-op reset: rst_n=0 for one edge on the 2nd BUSY cycle -> out_valid=0, out_p=0, in_ready=1; next accept of a=2, b=3 gives 6.
REQ-031 Zero and busy-ignore: a=0, b=13 -> out_p=0 after 4 edges; in_valid toggled with a=5, b=5 during BUSY -> no extra result, out_p unchanged.
REQ-032 Exhaustive: all 256 (a,b) pairs in both modes checked against the bit-level model of REQ-017/REQ-018, mod 2^OUT_W, also with OUT_W=6.
